// File: rtl/relu_backward.sv
// Purpose : ReLU backward gate. Records a mask bit per forward activation, then gates gradients with them.
// Latency : 1 cycle from gradient acceptance to grad_out_valid; push visible in mask_count next cycle.
// Backpres: grad_out holds while !grad_out_ready; grad_ready drops. fwd_ready drops when the mask FIFO is full.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous flush of mask FIFO, output valid and error flag (wins over push/pop)
//   fwd_*           forward tap: signed pre-activation value, valid/ready
//   grad_in/_valid/_ready        upstream gradient dL/dy
//   grad_out/_valid/_ready       gated gradient dL/dx
//   mask_count      number of mask bits currently stored
//   underflow_err   sticky: a gradient was offered while no mask was stored
//
// Build option: define RELU_BWD_LEAKY_EN for the leaky-ReLU derivative, where a
// mask-0 entry yields grad_in >>> LEAK_SHIFT instead of zero.
module relu_backward #(
    parameter int DEPTH      = 64,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [31:0]            fwd_data,
    input  logic                   fwd_valid,
    output logic                   fwd_ready,
    input  logic [31:0]            grad_in,
    input  logic                   grad_valid,
    output logic                   grad_ready,
    output logic [31:0]            grad_out,
    output logic                   grad_out_valid,
    input  logic                   grad_out_ready,
    output logic [$clog2(DEPTH):0] mask_count,
    output logic                   underflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Parameter sanity: pointers wrap naturally only for power-of-two depths.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("relu_backward: DEPTH must be a power of two >= 2");
    end
    if ((LEAK_SHIFT < 0) || (LEAK_SHIFT > 31)) begin : g_bad_shift
        $error("relu_backward: LEAK_SHIFT must be in 0..31");
    end

    logic          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          fwd_pos;
    logic          rd_mask;
    logic [31:0]   gated;

    // Ready signals depend only on registered state, never on the valids.
    assign fwd_ready  = (count != FULL_CNT);
    assign grad_ready = (count != '0) && (!grad_out_valid || grad_out_ready);
    assign mask_count = count;

    assign push = fwd_valid  && fwd_ready  && !clear;
    assign pop  = grad_valid && grad_ready && !clear;

    // Strictly positive: sign bit clear and not all-zero.
    assign fwd_pos = !fwd_data[31] && (fwd_data != 32'h0);

    assign rd_mask = mem[rptr];

`ifdef RELU_BWD_LEAKY_EN
    logic [31:0] leaked;
    assign leaked = 32'($signed(grad_in) >>> LEAK_SHIFT);
    assign gated  = rd_mask ? grad_in : leaked;
`else
    assign gated  = rd_mask ? grad_in : 32'h0;
`endif

    // Mask storage has no reset; contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= fwd_pos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            grad_out       <= '0;
            grad_out_valid <= 1'b0;
            underflow_err  <= 1'b0;
        end else if (clear) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            grad_out_valid <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A new accept refills the register; otherwise a taken result empties it
            // while grad_out keeps its last value.
            if (pop) begin
                grad_out       <= gated;
                grad_out_valid <= 1'b1;
            end else if (grad_out_ready) begin
                grad_out_valid <= 1'b0;
            end

            if (grad_valid && (count == '0)) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_relu_backward.sv
module tb_relu_backward;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [31:0] fwd_data;
    logic        fwd_valid;
    logic        fwd_ready;
    logic [31:0] grad_in;
    logic        grad_valid;
    logic        grad_ready;
    logic [31:0] grad_out;
    logic        grad_out_valid;
    logic        grad_out_ready;
    logic [6:0]  mask_count;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;

    bit exp_mask[$];

    relu_backward #(.DEPTH(64), .LEAK_SHIFT(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .fwd_data       (fwd_data),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .grad_in        (grad_in),
        .grad_valid     (grad_valid),
        .grad_ready     (grad_ready),
        .grad_out       (grad_out),
        .grad_out_valid (grad_out_valid),
        .grad_out_ready (grad_out_ready),
        .mask_count     (mask_count),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output for a given mask bit; mask-0 handling depends on the build.
    function automatic logic [31:0] exp_grad(input bit m, input logic [31:0] g);
`ifdef RELU_BWD_LEAKY_EN
        logic [31:0] s;
        s = {{3{g[31]}}, g[31:3]};
        return m ? g : s;
`else
        return m ? g : 32'h0;
`endif
    endfunction

    // Drivers: called at a negedge, hold inputs across one posedge, return at the next negedge.
    task automatic push(input logic [31:0] d);
        fwd_data  = d;
        fwd_valid = 1'b1;
        @(negedge clk);
        fwd_valid = 1'b0;
    endtask

    task automatic pop(input logic [31:0] g);
        grad_in    = g;
        grad_valid = 1'b1;
        @(negedge clk);
        grad_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (grad_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", grad_out_valid); end
        checks++; if (grad_out !== 32'h0) begin errors++; $display("FAIL reset_grad_out got %h exp 0", grad_out); end
        checks++; if (mask_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", mask_count); end
        checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow_err); end
        checks++; if (fwd_ready !== 1'b1) begin errors++; $display("FAIL reset_fwd_ready got %b exp 1", fwd_ready); end
        checks++; if (grad_ready !== 1'b0) begin errors++; $display("FAIL reset_grad_ready got %b exp 0", grad_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] g   [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
        bit          msk [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        push(32'd5);
        push(32'hFFFFFFFD);
        push(32'h0);
        push(32'h7FFFFFFF);
        checks++; if (mask_count !== 7'd4) begin errors++; $display("FAIL basic_count_full got %0d exp 4", mask_count); end
        for (int i = 0; i < 4; i++) begin
            pop(g[i]);
            checks++; if (grad_out_valid !== 1'b1 || grad_out !== exp_grad(msk[i], g[i])) begin
                errors++; $display("FAIL basic_out%0d got %b/%h exp 1/%h", i, grad_out_valid, grad_out, exp_grad(msk[i], g[i]));
            end
            checks++; if (mask_count !== 7'(3 - i)) begin errors++; $display("FAIL basic_count%0d got %0d exp %0d", i, mask_count, 3 - i); end
        end
        @(negedge clk);
        checks++; if (grad_out_valid !== 1'b0 || grad_out !== exp_grad(1'b1, 32'h40)) begin
            errors++; $display("FAIL basic_drain got %b/%h exp 0/%h", grad_out_valid, grad_out, exp_grad(1'b1, 32'h40));
        end
    endtask

    task automatic test_full_wrap;
        int          bad = 0;
        bit          m;
        logic [31:0] g;
        for (int i = 0; i < 64; i++) begin
            if (i == 2) begin
                push(32'h80000000); exp_mask.push_back(1'b0);
            end else if (i % 2 == 1) begin
                push(32'(i)); exp_mask.push_back(1'b1);
            end else begin
                push(-32'(i)); exp_mask.push_back(1'b0);
            end
        end
        checks++; if (fwd_ready !== 1'b0) begin errors++; $display("FAIL full_fwd_ready got %b exp 0", fwd_ready); end
        checks++; if (mask_count !== 7'd64) begin errors++; $display("FAIL full_count got %0d exp 64", mask_count); end
        push(32'd1);   // must be ignored
        checks++; if (mask_count !== 7'd64) begin errors++; $display("FAIL full_extra_push got %0d exp 64", mask_count); end
        for (int k = 0; k < 2; k++) begin
            m = exp_mask.pop_front(); g = 32'h100 + 32'(k);
            pop(g);
            checks++; if (grad_out !== exp_grad(m, g)) begin errors++; $display("FAIL wrap_pre%0d got %h exp %h", k, grad_out, exp_grad(m, g)); end
        end
        push(32'd77);        exp_mask.push_back(1'b1);
        push(32'hFFFFFFFF);  exp_mask.push_back(1'b0);
        checks++; if (mask_count !== 7'd64) begin errors++; $display("FAIL wrap_refill got %0d exp 64", mask_count); end
        for (int k = 0; k < 64; k++) begin
            m = exp_mask.pop_front(); g = 32'h2000 + 32'(k * 8);
            pop(g);
            if (grad_out_valid !== 1'b1 || grad_out !== exp_grad(m, g)) begin
                bad++; $display("FAIL wrap_drain%0d got %h exp %h", k, grad_out, exp_grad(m, g));
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (mask_count !== 7'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", mask_count); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        push(32'd1);
        push(32'd2);
        push(32'hFFFFFFFF);
        grad_out_ready = 1'b0;
        grad_in = 32'hAAA; grad_valid = 1'b1;
        @(negedge clk);
        grad_in = 32'hBBB;
        for (int k = 0; k < 3; k++) begin
            checks++; if (grad_out_valid !== 1'b1 || grad_out !== 32'hAAA) begin
                errors++; $display("FAIL bp_hold%0d got %b/%h exp 1/00000aaa", k, grad_out_valid, grad_out);
            end
            checks++; if (grad_ready !== 1'b0 || mask_count !== 7'd2) begin
                errors++; $display("FAIL bp_stall%0d got rdy %b cnt %0d exp 0/2", k, grad_ready, mask_count);
            end
            @(negedge clk);
        end
        grad_out_ready = 1'b1;
        #1;
        checks++; if (grad_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", grad_ready); end
        @(negedge clk);
        grad_valid = 1'b0;
        checks++; if (grad_out !== 32'hBBB || mask_count !== 7'd1) begin
            errors++; $display("FAIL bp_second got %h cnt %0d exp 00000bbb/1", grad_out, mask_count);
        end
        @(negedge clk);
        checks++; if (grad_out_valid !== 1'b0 || grad_out !== 32'hBBB) begin
            errors++; $display("FAIL bp_idle got %b/%h exp 0/00000bbb", grad_out_valid, grad_out);
        end
        pop(32'hCCC);
        checks++; if (grad_out !== exp_grad(1'b0, 32'hCCC)) begin errors++; $display("FAIL bp_last got %h exp %h", grad_out, exp_grad(1'b0, 32'hCCC)); end
    endtask

    task automatic test_simul;
        push(32'd9);
        fwd_data = 32'hFFFFFFFB; fwd_valid = 1'b1;
        grad_in  = 32'h55;       grad_valid = 1'b1;
        #1;
        checks++; if (fwd_ready !== 1'b1 || grad_ready !== 1'b1) begin
            errors++; $display("FAIL simul_ready got %b/%b exp 1/1", fwd_ready, grad_ready);
        end
        @(negedge clk);
        fwd_valid = 1'b0; grad_valid = 1'b0;
        checks++; if (mask_count !== 7'd1) begin errors++; $display("FAIL simul_count got %0d exp 1", mask_count); end
        checks++; if (grad_out !== 32'h55) begin errors++; $display("FAIL simul_old_mask got %h exp 00000055", grad_out); end
        pop(32'h66);
        checks++; if (grad_out !== exp_grad(1'b0, 32'h66)) begin errors++; $display("FAIL simul_new_mask got %h exp %h", grad_out, exp_grad(1'b0, 32'h66)); end
        @(negedge clk);
    endtask

    task automatic test_underflow_clear;
        grad_in = 32'h99; grad_valid = 1'b1;
        fwd_data = 32'd3; fwd_valid = 1'b1;
        #1;
        checks++; if (grad_ready !== 1'b0) begin errors++; $display("FAIL uf_grad_ready got %b exp 0", grad_ready); end
        @(negedge clk);
        grad_valid = 1'b0; fwd_valid = 1'b0;
        checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_flag got %b exp 1", underflow_err); end
        checks++; if (grad_out_valid !== 1'b0 || mask_count !== 7'd1) begin
            errors++; $display("FAIL uf_no_bypass got %b cnt %0d exp 0/1", grad_out_valid, mask_count);
        end
        @(negedge clk);
        checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", underflow_err); end
        grad_out_ready = 1'b0;
        pop(32'h44);
        checks++; if (grad_out_valid !== 1'b1 || grad_out !== 32'h44) begin
            errors++; $display("FAIL uf_pending got %b/%h exp 1/00000044", grad_out_valid, grad_out);
        end
        clear = 1'b1; fwd_data = 32'd1; fwd_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; fwd_valid = 1'b0;
        checks++; if (underflow_err !== 1'b0 || mask_count !== 7'd0 || grad_out_valid !== 1'b0) begin
            errors++; $display("FAIL clear got uf %b cnt %0d vld %b exp 0/0/0", underflow_err, mask_count, grad_out_valid);
        end
        grad_out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        grad_valid = 1'b1; grad_in = 32'h1;
        @(negedge clk);
        grad_valid = 1'b0;
        push(32'd1);
        push(32'd2);
        grad_out_ready = 1'b0;
        pop(32'h1234);
        checks++; if (underflow_err !== 1'b1 || grad_out !== 32'h1234 || mask_count !== 7'd1) begin
            errors++; $display("FAIL arst_pre got uf %b out %h cnt %0d exp 1/00001234/1", underflow_err, grad_out, mask_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (grad_out !== 32'h0 || grad_out_valid !== 1'b0) begin
            errors++; $display("FAIL arst_out got %b/%h exp 0/0", grad_out_valid, grad_out);
        end
        checks++; if (mask_count !== 7'd0 || underflow_err !== 1'b0 || fwd_ready !== 1'b1) begin
            errors++; $display("FAIL arst_state got cnt %0d uf %b rdy %b exp 0/0/1", mask_count, underflow_err, fwd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        grad_out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_leaky;
        logic [31:0] e1;
`ifdef RELU_BWD_LEAKY_EN
        e1 = 32'hFFFFFFF8;
`else
        e1 = 32'h0;
`endif
        push(32'hFFFFFFFF);
        push(32'h0);
        pop(32'hFFFFFFC0);
        checks++; if (grad_out !== e1) begin errors++; $display("FAIL leaky_neg got %h exp %h", grad_out, e1); end
        pop(32'd7);
        checks++; if (grad_out !== 32'h0) begin errors++; $display("FAIL leaky_small got %h exp 0", grad_out); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        fwd_data = '0; fwd_valid = 1'b0;
        grad_in = '0; grad_valid = 1'b0; grad_out_ready = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_full_wrap;
        test_backpressure;
        test_simul;
        test_underflow_clear;
        test_async_reset;
        test_leaky;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_backward.md
Name: relu_backward

Overview:
- Backward-pass counterpart to the ReLU activation stage, used for on-chip training.
- During the forward pass, records one mask bit per activation: 1 if the signed pre-activation input is > 0.
- During the backward pass, gates incoming gradients with those bits in FIFO order: pass the gradient if the bit is 1, else output zero.
- Sits between the forward activation stream (tap side) and the backpropagation datapath.

Parameters:
- DEPTH, 64, mask FIFO entries; power of 2, >= 2.
- LEAK_SHIFT, 3, arithmetic right-shift applied to masked gradients; used only when RELU_BWD_LEAKY_EN is defined.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of mask FIFO and output register.
- fwd_data  input  32  signed pre-activation value (forward pass).
- fwd_valid  input  1  fwd_data valid.
- fwd_ready  output  1  mask FIFO can accept an entry.
- grad_in  input  32  signed upstream gradient dL/dy.
- grad_valid  input  1  grad_in valid.
- grad_ready  output  1  gradient accepted this cycle.
- grad_out  output  32  signed gated gradient dL/dx.
- grad_out_valid  output  1  grad_out valid.
- grad_out_ready  input  1  downstream accepts grad_out.
- mask_count  output  $clog2(DEPTH)+1  mask entries currently stored.
- underflow_err  output  1  sticky: a gradient was presented while the FIFO was empty.

Behaviour:
- Reset (rst_n low, async): all of the following are cleared.
  - Write pointer, read pointer and count = 0.
  - grad_out = 0, grad_out_valid = 0, underflow_err = 0.
  - Mask storage contents are don't-care.
- Push (forward capture):
  - fwd_ready = (count != DEPTH), registered-state based with no combinational path from fwd_valid.
  - On fwd_valid && fwd_ready: mem[wptr] <= ($signed(fwd_data) > 0); wptr increments and wraps modulo DEPTH.
  - Zero and negative values (0x00000000, 0x80000000) store 0.
- Pop (backward gating):
  - grad_ready = (count != 0) && (!grad_out_valid || grad_out_ready).
  - On grad_valid && grad_ready, next edge: grad_out <= mem[rptr] ? grad_in : 0; grad_out_valid <= 1; rptr increments and wraps.
  - Latency is 1 cycle from acceptance to grad_out_valid.
- Output register:
  - If grad_out_valid && grad_out_ready and no new accept: grad_out_valid <= 0 and grad_out holds its value.
  - Back-to-back accept with grad_out_ready held high gives 1 result per cycle.
  - grad_out and grad_out_valid must hold stable while grad_out_valid && !grad_out_ready.
- Count:
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.
  - Simultaneous push and pop is legal whenever 0 < count < DEPTH.
  - When full, push is blocked even if a pop occurs that cycle.
  - When empty, pop is blocked; a same-cycle push is not bypassed.
- Ordering: strict FIFO. The Nth gradient accepted uses the Nth mask captured since the last reset or clear.
- underflow_err: set when grad_valid && count == 0. Sticky; cleared only by reset or clear.
- clear (synchronous, highest priority):
  - Pointers, count, grad_out_valid and underflow_err go to 0.
  - Any push or pop in that cycle is ignored.
  - grad_out is not required to change.
- No arithmetic on the passthrough path; all 32 bits are copied unchanged.

Optional Feature:
- Macro: RELU_BWD_LEAKY_EN.
- Defined: leaky-ReLU derivative. A mask-0 entry yields grad_out = $signed(grad_in) >>> LEAK_SHIFT (arithmetic shift, sign-extended, truncating toward -inf). Mask-1 entries pass unchanged.
- Undefined: a mask-0 entry yields 32'h0. LEAK_SHIFT is unused, and the module has no shift logic.

Test Plan:
- Basic gating:
  - Stimulus: push fwd_data 5, -3, 0, 0x7FFFFFFF; then gradients 0x10, 0x20, 0x30, 0x40 with grad_out_ready=1.
  - Required: grad_out 0x10, 0, 0, 0x40 (non-leaky), each 1 cycle after accept; mask_count goes 4 -> 0.
- Full/wrap:
  - Stimulus: push DEPTH entries.
  - Required: fwd_ready=0 and mask_count=DEPTH; extra fwd_valid is ignored.
  - Stimulus: pop 2 entries, push 2 more, drain all.
  - Required: outputs in exact push order across the pointer wrap.
- Backpressure:
  - Stimulus: grad_out_ready=0 for 3 cycles with grad_valid=1.
  - Required: first grad_out held stable with valid=1; grad_ready=0; no mask consumed until ready rises.
- Simultaneous push/pop:
  - Stimulus: count=1, push and pop in the same cycle.
  - Required: count stays 1 and the popped value uses the older mask.
- Underflow and clear:
  - Stimulus: grad_valid with FIFO empty.
  - Required: underflow_err=1, grad_ready=0.
  - Stimulus: clear pulse.
  - Required: underflow_err=0, count=0, grad_out_valid=0. Async rst_n mid-stream likewise zeroes all outputs immediately.
- Leaky (RELU_BWD_LEAKY_EN, LEAK_SHIFT=3):
  - Stimulus: mask 0 with grad_in -64 (0xFFFFFFC0).
  - Required: grad_out -8 (0xFFFFFFF8).
  - Stimulus: mask 0 with grad_in 7.
  - Required: grad_out 0.
